// File: rtl/mat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mat_pkg
// Purpose  : Shared defaults, index-width helper and FSM state type for the
//            matrix result streamer.
// Revision : 1.0 - initial release
// ============================================================================
package mat_pkg;

    localparam int c_DIM_DEFAULT   = 8;
    localparam int c_CW_DEFAULT    = 32;
    localparam int c_IDX_W_DEFAULT = $clog2(c_DIM_DEFAULT);

    // Guard against a zero-width index when DIM collapses to 1.
    function automatic int idx_width(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mat_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer_if
// Purpose  : Valid/ready element stream carrying one matrix element per beat
//            together with its row/column index and a last-element flag.
// Revision : 1.0 - initial release
// ============================================================================
interface mat_result_streamer_if #(
    parameter int DIM = mat_pkg::c_DIM_DEFAULT,
    parameter int CW  = mat_pkg::c_CW_DEFAULT
);
    import mat_pkg::*;

    localparam int c_IW = idx_width(DIM);

    logic            out_valid;
    logic            out_ready;
    logic [CW-1:0]   out_data;
    logic [c_IW-1:0] out_row;
    logic [c_IW-1:0] out_col;
    logic            out_last;

    modport master (
        output out_valid, out_data, out_row, out_col, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_row, out_col, out_last,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/mat_idx_counter.sv
`default_nettype none
// ============================================================================
// Module   : mat_idx_counter
// Purpose  : Two-dimensional (row, col) element index with wrap; row-major by
//            default, column-major when MAT_STREAM_COLMAJOR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mat_idx_counter
    import mat_pkg::*;
#(
    parameter int DIM = c_DIM_DEFAULT
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_clr,
    input  wire logic                      i_adv,
    output logic      [idx_width(DIM)-1:0] o_row,
    output logic      [idx_width(DIM)-1:0] o_col,
    output logic                           o_last
);

    localparam int              c_IW  = idx_width(DIM);
    localparam logic [c_IW-1:0] c_MAX = c_IW'(DIM - 1);

    logic [c_IW-1:0] r_row;
    logic [c_IW-1:0] r_col;
    logic            w_row_wrap;
    logic            w_col_wrap;

    assign w_row_wrap = (r_row == c_MAX);
    assign w_col_wrap = (r_col == c_MAX);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
`ifdef MAT_STREAM_COLMAJOR_EN
            if (w_row_wrap) begin
                r_row <= '0;
                r_col <= w_col_wrap ? '0 : r_col + 1'b1;
            end else begin
                r_row <= r_row + 1'b1;
            end
`else
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
`endif
        end
    end

    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_row_wrap && w_col_wrap;

endmodule
`default_nettype wire

// File: rtl/mat_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mat_result_streamer
// Purpose  : Captures a finished result matrix on the rising edge of done and
//            streams it element by element over a valid/ready interface.
//            Build option: MAT_STREAM_COLMAJOR_EN selects column-major order.
// Revision : 1.0 - initial release
// ============================================================================
module mat_result_streamer
    import mat_pkg::*;
#(
    parameter int DIM = c_DIM_DEFAULT,
    parameter int CW  = c_CW_DEFAULT
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   done,
    input  wire logic [DIM*DIM*CW-1:0]  C,
    output logic                        busy,
    output logic                        overrun,
    mat_result_streamer_if.master       res
);

    localparam int c_IW = idx_width(DIM);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_done_q;
    logic            r_overrun;
    logic            w_cap;
    logic            w_hs;
    logic            w_last_hs;
    logic            w_load;
    logic            w_adv;
    logic            w_ovr_set;
    logic [c_IW-1:0] w_row;
    logic [c_IW-1:0] w_col;
    logic            w_last;
    logic [CW-1:0]   r_buf [DIM][DIM];

    assign w_cap     = done & ~r_done_q;
    assign w_hs      = res.out_valid & res.out_ready;
    assign w_last_hs = w_hs & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_done_q  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= done;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // A capture landing on the final handshake chains straight into a new
    // stream; any other capture while streaming is dropped and flagged.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_ovr_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cap) begin
                    w_state_nxt = STREAM;
                    w_load      = 1'b1;
                end
            end
            STREAM: begin
                if (w_last_hs) begin
                    if (w_cap) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_adv     = w_hs;
                    w_ovr_set = w_cap;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Data buffer deliberately carries no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    r_buf[r][c] <= C[(r*DIM+c)*CW +: CW];
                end
            end
        end
    end

    mat_idx_counter #(
        .DIM (DIM)
    ) u_idx (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_load | w_last_hs),
        .i_adv  (w_adv),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_last (w_last)
    );

    assign busy          = (r_state == STREAM);
    assign overrun       = r_overrun;
    assign res.out_valid = busy;
    assign res.out_row   = w_row;
    assign res.out_col   = w_col;
    assign res.out_last  = busy & w_last;
    assign res.out_data  = busy ? r_buf[w_row][w_col] : '0;

endmodule
`default_nettype wire

// File: tb/tb_mat_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mat_result_streamer
// Purpose  : Self-checking bench; expected beats come from a captured copy of
//            the matrix indexed by beat number in the configured order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mat_result_streamer;
    import mat_pkg::*;

    localparam int DIM = 8;
    localparam int CW  = 32;
    localparam int NB  = DIM * DIM;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  done;
    logic [DIM*DIM*CW-1:0] C;
    logic                  busy;
    logic                  overrun;

    mat_result_streamer_if #(.DIM(DIM), .CW(CW)) sif ();

    mat_result_streamer #(.DIM(DIM), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .done    (done),
        .C       (C),
        .busy    (busy),
        .overrun (overrun),
        .res     (sif)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] tb_mat [DIM][DIM];
    logic [CW-1:0] m_cap  [DIM][DIM];
    logic [CW+6:0] obs;
    int            n_checks = 0;
    int            n_pass   = 0;

    assign obs = {sif.out_data, sif.out_row, sif.out_col, sif.out_last};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_c(input int mode);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                case (mode)
                    0:       tb_mat[r][c] = CW'(r * 8 + c);
                    1:       tb_mat[r][c] = 32'hFFFF_FFFF;
                    2:       tb_mat[r][c] = CW'(100 + r * 8 + c);
                    default: tb_mat[r][c] = $urandom;
                endcase
                C[(r*DIM+c)*CW +: CW] = tb_mat[r][c];
            end
        end
    endtask

    // Beat k of a stream: element position follows from the order rule.
    function automatic logic [CW+6:0] exp_beat(input int k);
        int r;
        int c;
`ifdef MAT_STREAM_COLMAJOR_EN
        r = k % DIM;
        c = k / DIM;
`else
        r = k / DIM;
        c = k % DIM;
`endif
        return {m_cap[r][c], 3'(r), 3'(c), (k == NB - 1)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; done = 1'b0; sif.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sif.out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_checks++; if (sif.out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", sif.out_last); else n_pass++;
        n_checks++; if ({sif.out_row, sif.out_col} !== 6'd0) $display("FAIL reset_index: got %0d,%0d want 0,0", sif.out_row, sif.out_col); else n_pass++;
        n_checks++; if (sif.out_data !== '0) $display("FAIL reset_data: got %h want 0", sif.out_data); else n_pass++;
    endtask

    task automatic test_order();
        int beats = 0;
        int cyc   = 0;
        load_c(0); m_cap = tb_mat;
        sif.out_ready = 1'b1; done = 1'b1;
        tick();
        done = 1'b0;
        n_checks++; if (sif.out_valid !== 1'b1 || obs !== exp_beat(0)) $display("FAIL latency: valid=%b beat=%h want valid=1 beat=%h", sif.out_valid, obs, exp_beat(0)); else n_pass++;
        while (beats < NB && cyc < 200) begin
            if (sif.out_valid && sif.out_ready) begin
                n_checks++; if (obs !== exp_beat(beats)) $display("FAIL order_beat%0d: got %h want %h", beats, obs, exp_beat(beats)); else n_pass++;
                beats++;
            end
            tick(); cyc++;
        end
        n_checks++; if (beats != NB || cyc != NB) $display("FAIL order_count: beats=%0d cycles=%0d want %0d/%0d", beats, cyc, NB, NB); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) $display("FAIL order_end: busy=%b valid=%b want 0/0", busy, sif.out_valid); else n_pass++;
    endtask

    task automatic test_stall();
        int beats = 0;
        int cyc   = 0;
        load_c(0); m_cap = tb_mat;
        sif.out_ready = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        while (beats < NB && cyc < 300) begin
            logic          stall;
            logic [CW+6:0] prev;
            sif.out_ready = (cyc % 2 == 0);
            stall = sif.out_valid && !sif.out_ready;
            prev  = obs;
            if (sif.out_valid && sif.out_ready) begin
                n_checks++; if (obs !== exp_beat(beats)) $display("FAIL stall_beat%0d: got %h want %h", beats, obs, exp_beat(beats)); else n_pass++;
                beats++;
            end
            tick(); cyc++;
            if (stall) begin
                n_checks++; if (sif.out_valid !== 1'b1 || obs !== prev) $display("FAIL stall_hold%0d: valid=%b beat=%h want 1 %h", cyc, sif.out_valid, obs, prev); else n_pass++;
            end
        end
        n_checks++; if (beats != NB || cyc > 2 * NB) $display("FAIL stall_count: beats=%0d cycles=%0d want %0d within %0d", beats, cyc, NB, 2 * NB); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL stall_end: busy=%b want 0", busy); else n_pass++;
    endtask

    task automatic test_overrun();
        int beats = 0;
        int cyc   = 0;
        load_c(0); m_cap = tb_mat;
        sif.out_ready = 1'b1; done = 1'b1;
        tick();
        while (beats < NB && cyc < 200) begin
            done = 1'b0;
            if (beats == 10 && cyc == 10) begin
                load_c(1);
                done = 1'b1;
            end
            if (sif.out_valid && sif.out_ready) begin
                n_checks++; if (obs !== exp_beat(beats)) $display("FAIL overrun_beat%0d: got %h want %h", beats, obs, exp_beat(beats)); else n_pass++;
                beats++;
            end
            tick(); cyc++;
        end
        done = 1'b0;
        n_checks++; if (beats != NB) $display("FAIL overrun_count: beats=%0d want %0d", beats, NB); else n_pass++;
        tick(); tick(); tick();
        n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b want 1", overrun); else n_pass++;
        n_checks++; if (busy !== 1'b0 || sif.out_valid !== 1'b0) $display("FAIL overrun_idle: busy=%b valid=%b want 0/0", busy, sif.out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int beats = 0;
        int cyc   = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        load_c(0); m_cap = tb_mat;
        sif.out_ready = 1'b1; done = 1'b1;
        tick();
        done = 1'b0;
        while (beats < NB && cyc < 200) begin
            if (beats == NB - 1) begin
                load_c(2);
                done = 1'b1;
            end
            if (sif.out_valid && sif.out_ready) begin
                n_checks++; if (obs !== exp_beat(beats)) $display("FAIL b2b_beat%0d: got %h want %h", beats, obs, exp_beat(beats)); else n_pass++;
                beats++;
            end
            tick(); cyc++;
            done = 1'b0;
        end
        n_checks++; if (sif.out_valid !== 1'b1 || obs !== {CW'(100), 7'd0}) $display("FAIL b2b_restart: valid=%b beat=%h want 1 %h", sif.out_valid, obs, {CW'(100), 7'd0}); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else n_pass++;
        m_cap = tb_mat;
        beats = 0; cyc = 0;
        while (beats < NB && cyc < 200) begin
            if (sif.out_valid && sif.out_ready) begin
                n_checks++; if (obs !== exp_beat(beats)) $display("FAIL b2b_second%0d: got %h want %h", beats, obs, exp_beat(beats)); else n_pass++;
                beats++;
            end
            tick(); cyc++;
        end
        n_checks++; if (beats != NB || busy !== 1'b0) $display("FAIL b2b_end: beats=%0d busy=%b want %0d 0", beats, busy, NB); else n_pass++;
    endtask

    task automatic test_midreset();
        int beats = 0;
        int cyc   = 0;
        load_c(0); m_cap = tb_mat;
        sif.out_ready = 1'b1; done = 1'b1;
        tick();
        done = 1'b0;
        while (beats < 20 && cyc < 100) begin
            if (sif.out_valid && sif.out_ready) beats++;
            tick(); cyc++;
        end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if ({sif.out_valid, busy, overrun} !== 3'b000) $display("FAIL midreset_flags: valid/busy/overrun=%b want 000", {sif.out_valid, busy, overrun}); else n_pass++;
        tick(); tick();
        n_checks++; if (sif.out_valid !== 1'b0) $display("FAIL midreset_idle: valid=%b want 0", sif.out_valid); else n_pass++;
        done = 1'b1; tick(); done = 1'b0;
        n_checks++; if (sif.out_valid !== 1'b1 || obs !== exp_beat(0)) $display("FAIL midreset_restart: valid=%b beat=%h want 1 %h", sif.out_valid, obs, exp_beat(0)); else n_pass++;
        beats = 0; cyc = 0;
        while (beats < NB && cyc < 200) begin
            if (sif.out_valid && sif.out_ready) begin
                n_checks++; if (obs !== exp_beat(beats)) $display("FAIL midreset_beat%0d: got %h want %h", beats, obs, exp_beat(beats)); else n_pass++;
                beats++;
            end
            tick(); cyc++;
        end
        n_checks++; if (beats != NB || busy !== 1'b0) $display("FAIL midreset_end: beats=%0d busy=%b want %0d 0", beats, busy, NB); else n_pass++;
    endtask

    // Random matrices and back-pressure; done stays high for several cycles.
    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int beats = 0;
            int cyc   = 0;
            load_c(3); m_cap = tb_mat;
            done = 1'b1; sif.out_ready = 1'b0;
            tick();
            while (beats < NB && cyc < 1000) begin
                done = (cyc < 3);
                if (cyc == 5) load_c(3);
                sif.out_ready = ($urandom_range(0, 3) != 0);
                if (sif.out_valid && sif.out_ready) begin
                    n_checks++; if (obs !== exp_beat(beats)) $display("FAIL random%0d_beat%0d: got %h want %h", it, beats, obs, exp_beat(beats)); else n_pass++;
                    beats++;
                end
                tick(); cyc++;
            end
            done = 1'b0;
            n_checks++; if (beats != NB || busy !== 1'b0 || overrun !== 1'b0) $display("FAIL random%0d_end: beats=%0d busy=%b overrun=%b want %0d 0 0", it, beats, busy, overrun, NB); else n_pass++;
            tick(); tick();
        end
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; C = '0; sif.out_ready = 1'b0;
        test_reset();
        test_order();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mat_result_streamer.md
MAT_RESULT_STREAMER -- requirements
Module: mat_result_streamer

Interface
REQ-001 Parameter DIM, default 8, matrix dimension (rows = columns).
REQ-002 Parameter CW, default 32, width of one result element in bits.
REQ-003 clk  input  1  sole clock; all logic updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 done  input  1  completion flag from the upstream matrix multiplier.
REQ-006 C  input  DIM*DIM*CW  flattened result matrix; element (r,c) occupies bits [(r*DIM+c)*CW +: CW].
REQ-007 out_valid  output  1  out_data, out_row, out_col and out_last are valid.
REQ-008 out_ready  input  1  downstream consumer accepts the current beat.
REQ-009 out_data  output  CW  current element.
REQ-010 out_row, out_col  output  $clog2(DIM) each  index of the current element.
REQ-011 out_last  output  1  current beat is the final element of the matrix.
REQ-012 busy  output  1  a captured matrix is still being streamed.
REQ-013 overrun  output  1  sticky; a done edge arrived while busy.

Function
REQ-014 The block SHALL register done (done_q); a capture event is done & ~done_q. A done held high SHALL cause exactly one capture.
REQ-015 The FSM SHALL have two states, IDLE and STREAM.
- IDLE -> STREAM on a capture event.
- STREAM -> IDLE on the handshake of the last beat.
REQ-016 On a capture event in IDLE, the block SHALL copy all of C into an internal DIM*DIM*CW buffer and reset the index to (0,0).
REQ-017 Latency: a capture event sampled at edge N SHALL give out_valid=1 with element (0,0) after edge N (cycle N+1).
REQ-018 Handshake: a beat transfers on any edge with out_valid & out_ready.
- While out_valid & ~out_ready, out_data, out_row, out_col and out_last SHALL hold stable.
- out_valid SHALL NOT drop before the beat transfers.
REQ-019 Default order SHALL be row-major: col increments, wraps DIM-1 -> 0 and increments row.
REQ-020 out_last SHALL be 1 only for index (DIM-1,DIM-1).
REQ-021 busy SHALL equal (state == STREAM); out_valid SHALL equal busy.
REQ-022 A capture event in STREAM that does not coincide with the last handshake SHALL set overrun.
- The buffer and the stream SHALL be left unchanged.
- overrun SHALL stay set until reset.
REQ-023 A capture event on the same edge as the last handshake SHALL be accepted.
- C is captured and the FSM stays in STREAM, restarting at (0,0) on the next cycle with no idle gap.
- overrun SHALL NOT be set.
REQ-024 C is sampled only at capture. Later changes to C SHALL NOT affect the beats being streamed.

Reset
REQ-025 On rst=1 at an edge the block SHALL force:
- state=IDLE, out_valid=0, busy=0, out_last=0, overrun=0, out_row=out_col=0, out_data=0, done_q=0.
REQ-026 The data buffer SHALL NOT be reset.
REQ-027 A reset in mid-stream SHALL abandon the stream. A later capture SHALL restart at (0,0).

Configuration
REQ-028 Macro MAT_STREAM_COLMAJOR_EN:
- Defined: order SHALL be column-major (row increments first, wraps, then col increments); out_last is unchanged at (DIM-1,DIM-1).
- Undefined: row-major per REQ-019.

Structure
REQ-029 Package mat_pkg SHALL hold DIM/CW defaults, the index width localparam and the IDLE/STREAM state typedef.
REQ-030 The two-dimensional index counter with wrap and order select SHALL be the sub-module mat_idx_counter.

Verification
REQ-031 C(r,c)=r*8+c, single done pulse, out_ready=1 -> 64 consecutive beats with data 0..63, out_last on beat 64, busy=0 the following cycle.
REQ-032 Same C, out_ready alternating 1,0 -> all outputs stable during each stall, 64 beats in 128 cycles, order unchanged.
REQ-033 Second done pulse at beat 10 with C=all 0xFFFF_FFFF -> overrun=1, beats 10..63 still carry the original values, FSM returns to IDLE.
REQ-034 Second done edge on the last-handshake edge with C(r,c)=100+r*8+c -> next cycle out_valid=1 with data 100 at (0,0), overrun=0.
REQ-035 rst=1 for one edge at beat 20 -> out_valid=busy=overrun=0 next cycle; a new done restarts at (0,0) with data 0.
REQ-036 MAT_STREAM_COLMAJOR_EN defined, C(r,c)=r*8+c -> data sequence 0,8,16,...,56,1,9,...,63, out_last on value 63.
